ahb_ram_responder: RTL

- AHB-Lite responder (slave) with a word-organised RAM behind it, carrying the custom bus protection fields (6-bit address-phase parity, 7-bit data checksums).
- It is the far end of the core's instruction and data bus masters.
- Used as the on-chip memory in SoC integration and as the responding model in core-level benches.
- It checks incoming parity and write checksums, and generates the read checksum.

---
 rtl/ahb_ram_responder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ahb_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : ahb_ram_responder
// Purpose  : AHB-Lite responder with a word-organised RAM. Checks address-phase
//            parity and write-data SEC-DED checksums, and generates the
//            read-data checksum.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_ram_responder #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_hsel_i,
    input  logic [31:0] s_haddr_i,
    input  logic [1:0]  s_htrans_i,
    input  logic [2:0]  s_hsize_i,
    input  logic        s_hwrite_i,
    input  logic [31:0] s_hwdata_i,
    input  logic [5:0]  s_hparity_i,
    input  logic [6:0]  s_hwchecksum_i,
    output logic [31:0] s_hrdata_o,
    output logic [6:0]  s_hrchecksum_o,
    output logic        s_hready_o,
    output logic        s_hresp_o
);

    localparam int         c_AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] c_BYTES    = 33'(4 * MEM_WORDS);
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_ERR1 = 2'd2;
    localparam logic [1:0] c_ERR2 = 2'd3;

    // SEC-DED (39,32): extended Hamming code. Data bits occupy the
    // non-power-of-two codeword positions 3..38 in ascending order; check bit
    // k covers every position with bit k set; bit 6 is the overall parity of
    // data plus the six check bits.
    function automatic logic [6:0] f_secded(input logic [31:0] i_d);
        logic [31:0] v_sh;
        logic [5:0]  v_c;
        v_sh = i_d;
        v_c  = '0;
        for (int pos = 3; pos < 39; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                v_c  = v_c ^ (6'(pos) & {6{v_sh[0]}});
                v_sh = v_sh >> 1;
            end
        end
        return {^{i_d, v_c}, v_c};
    endfunction

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [3:0]      r_wait_cnt;
    logic            r_dp_valid;
    logic            r_dp_first;
    logic            r_dp_write;
    logic            r_dp_err;
    logic [c_AW-1:0] r_dp_addr;
    logic [3:0]      r_dp_mask;

    logic [5:0]      w_par;
    logic            w_accept;
    logic            w_addr_err;
    logic [3:0]      w_mask;
    logic [1:0]      w_accept_state;
    logic            w_wr_ck_err;
    logic            w_wr_commit;
    logic            w_rd_complete;
    logic [31:0]     w_rd_word;

    // Even parity expected for the current address phase
    assign w_par = {^s_haddr_i[31:24], ^s_haddr_i[23:16], ^s_haddr_i[15:8],
                    ^s_haddr_i[7:0], ^{s_hwrite_i, s_hsize_i}, ^s_htrans_i};

    assign w_accept   = s_hsel_i & s_htrans_i[1] & s_hready_o;
    assign w_addr_err = (w_par != s_hparity_i)
                      | ({1'b0, s_haddr_i} >= c_BYTES)
                      | (s_hsize_i > 3'd2)
                      | ((s_hsize_i == 3'd1) & s_haddr_i[0])
                      | ((s_hsize_i == 3'd2) & (s_haddr_i[1:0] != 2'b00));

    // State entered by an accepted address phase
    assign w_accept_state = w_addr_err ? c_ERR1 : ((WAIT_STATES > 0) ? c_WAIT : c_IDLE);

    // Write checksum is judged once, in the first data-phase cycle; a mismatch
    // turns that cycle into the first error-response cycle.
    assign w_wr_ck_err = r_dp_valid & r_dp_first & r_dp_write & ~r_dp_err
                       & ((r_state == c_IDLE) | (r_state == c_WAIT))
                       & (f_secded(s_hwdata_i) != s_hwchecksum_i);

    assign w_wr_commit   = (r_state == c_IDLE) & r_dp_valid & r_dp_write & ~r_dp_err & ~w_wr_ck_err;
    assign w_rd_complete = (r_state == c_IDLE) & r_dp_valid & ~r_dp_write & ~r_dp_err;

    // Byte-lane mask derived from size and low address bits
    always_comb begin
        w_mask = 4'b1111;
        case (s_hsize_i[1:0])
            2'd0:    w_mask = 4'b0001 << s_haddr_i[1:0];
            2'd1:    w_mask = s_haddr_i[1] ? 4'b1100 : 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    // State register, wait counter and pending data-phase context
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            r_state    <= c_IDLE;
            r_wait_cnt <= 4'd0;
            r_dp_valid <= 1'b0;
            r_dp_first <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_err   <= 1'b0;
            r_dp_addr  <= '0;
            r_dp_mask  <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_accept && !w_addr_err) begin
                r_wait_cnt <= c_WAIT_LOAD;
            end else if ((r_state == c_WAIT) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_accept) begin
                r_dp_valid <= 1'b1;
                r_dp_first <= 1'b1;
                r_dp_write <= s_hwrite_i;
                r_dp_err   <= w_addr_err;
                r_dp_addr  <= s_haddr_i[c_AW+1:2];
                r_dp_mask  <= w_mask;
            end else begin
                r_dp_first <= 1'b0;
                if (r_dp_valid && s_hready_o) begin
                    r_dp_valid <= 1'b0;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_wr_ck_err)   w_next = c_ERR2;
                else if (w_accept) w_next = w_accept_state;
                else               w_next = c_IDLE;
            end
            c_WAIT: begin
                if (w_wr_ck_err)              w_next = c_ERR2;
                else if (r_wait_cnt == 4'd0) w_next = c_IDLE;
                else                          w_next = c_WAIT;
            end
            c_ERR1:  w_next = c_ERR2;
            default: w_next = w_accept ? w_accept_state : c_IDLE;
        endcase
    end

    // Response outputs decoded from state and the live write-checksum check
    always_comb begin
        s_hready_o = 1'b1;
        s_hresp_o  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_wr_ck_err) begin
                    s_hready_o = 1'b0;
                    s_hresp_o  = 1'b1;
                end
            end
            c_WAIT: begin
                s_hready_o = 1'b0;
                s_hresp_o  = w_wr_ck_err;
            end
            c_ERR1: begin
                s_hready_o = 1'b0;
                s_hresp_o  = 1'b1;
            end
            default: begin
                s_hready_o = 1'b1;
                s_hresp_o  = 1'b1;
            end
        endcase
    end

    // One byte-wide RAM per lane so each lane has a single writer
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_lane [MEM_WORDS];

        // Commit the lane on the completing edge of an unblocked write
        always_ff @(posedge s_clk_i) begin
            if (w_wr_commit && r_dp_mask[gi]) begin
                r_lane[r_dp_addr] <= s_hwdata_i[8*gi +: 8];
            end
        end

        assign w_rd_word[8*gi +: 8] = r_lane[r_dp_addr];
    end

    assign s_hrdata_o     = w_rd_complete ? w_rd_word : 32'd0;
    assign s_hrchecksum_o = f_secded(s_hrdata_o);

endmodule
`default_nettype wire
